// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan controller.
// Channel i maps to {S0,S1} = i[1:0]; NUM_CH marks "no channel".
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;

    // Channel index to {S0,S1} select pair.
    function automatic logic [1:0] ch_sel(input logic [1:0] ch);
        return {ch[1], ch[0]};
    endfunction

    // Lowest enabled channel, or NUM_CH when the mask is empty.
    function automatic logic [CH_W-1:0] first_en(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = CH_W'(NUM_CH);
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (m[j]) r = CH_W'(j);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, or NUM_CH if none.
    function automatic logic [CH_W-1:0] next_above(
        input logic [CH_W-1:0]   cur,
        input logic [NUM_CH-1:0] m
    );
        logic [CH_W-1:0] r;
        r = CH_W'(NUM_CH);
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (m[j] && (j > int'(cur))) r = CH_W'(j);
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Structural 4:1 multiplexer; S0 selects the pair, S1 the member.
// F = x[{S0,S1}] built from AND/OR terms.
module mux_4_to_1 (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic S0,
    input  logic S1,
    output logic F
);

    assign F = (x0 & ~S0 & ~S1) |
               (x1 & ~S0 &  S1) |
               (x2 &  S0 & ~S1) |
               (x3 &  S0 &  S1);

endmodule

// File: rtl/mux_scan_ctrl_dwell.sv
// Load/decrement dwell counter for the mux scan controller.
// done marks the last edge of a dwell period (count == 1).
module mux_scan_dwell #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(DWELL + 1);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down to zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(DWELL);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = en && (cnt == W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller driving a 4:1 mux select and snapshotting F per channel.
// Optional MUX_SCAN_DIFF_EN adds the changed output vs last accepted snap.
import mux_scan_pkg::*;

module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] mask,
    input  logic       F,
    output logic       S0,
    output logic       S1,
    output logic [3:0] snap,
    output logic       snap_valid,
    input  logic       snap_ready,
    output logic       busy
`ifdef MUX_SCAN_DIFF_EN
    ,
    output logic [3:0] changed
`endif
);

    scan_state_t     state, state_n;
    logic [3:0]      mask_q, mask_n;
    logic [CH_W-1:0] ch_q, ch_n;
    logic [CH_W-1:0] nxt;
    logic [3:0]      shadow_q, shadow_n;
    logic [3:0]      snap_q, snap_n;
    logic            valid_q, valid_n;
    logic [1:0]      sel_q, sel_n;
    logic            busy_q, busy_n;
    logic            hs;
    logic            launch;
    logic            dwell_load;
    logic            dwell_done;

    assign hs = valid_q && snap_ready;

    mux_scan_dwell #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .load (dwell_load),
        .en   (state == SCAN),
        .done (dwell_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic for the scan sequence.
    always_comb begin
        state_n    = state;
        mask_n     = mask_q;
        ch_n       = ch_q;
        shadow_n   = shadow_q;
        snap_n     = snap_q;
        valid_n    = valid_q;
        sel_n      = sel_q;
        dwell_load = 1'b0;
        launch     = 1'b0;
        nxt        = next_above(ch_q, mask_q);

        unique case (state)
            IDLE: begin
                launch = start;
            end
            SCAN: begin
                if (dwell_done) begin
                    shadow_n[ch_q[1:0]] = F;
                    if (nxt == CH_W'(NUM_CH)) begin
                        state_n = HOLD;
                        snap_n  = shadow_n;
                        valid_n = 1'b1;
                        sel_n   = 2'b00;
                    end else begin
                        ch_n       = nxt;
                        sel_n      = ch_sel(nxt[1:0]);
                        dwell_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hs) begin
                    valid_n = 1'b0;
                    if (cont) begin
                        launch = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Common scan launch from IDLE start or continuous restart.
        if (launch) begin
            mask_n   = mask;
            shadow_n = 4'b0000;
            if (mask == 4'b0000) begin
                state_n = HOLD;
                snap_n  = 4'b0000;
                valid_n = 1'b1;
                sel_n   = 2'b00;
            end else begin
                state_n    = SCAN;
                ch_n       = first_en(mask);
                sel_n      = ch_sel(ch_n[1:0]);
                dwell_load = 1'b1;
            end
        end

        busy_n = (state_n != IDLE);
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= 4'b0000;
            ch_q     <= '0;
            shadow_q <= 4'b0000;
            snap_q   <= 4'b0000;
            valid_q  <= 1'b0;
            sel_q    <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            mask_q   <= mask_n;
            ch_q     <= ch_n;
            shadow_q <= shadow_n;
            snap_q   <= snap_n;
            valid_q  <= valid_n;
            sel_q    <= sel_n;
            busy_q   <= busy_n;
        end
    end

    assign S0         = sel_q[1];
    assign S1         = sel_q[0];
    assign snap       = snap_q;
    assign snap_valid = valid_q;
    assign busy       = busy_q;

`ifdef MUX_SCAN_DIFF_EN
    logic [3:0] snap_ref;

    // Reference follows each accepted snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_ref <= 4'b0000;
        end else if (hs) begin
            snap_ref <= snap_q;
        end
    end

    assign changed = snap_q ^ snap_ref;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a mux_4_to_1 in the loop.
// Two instances: DWELL=2 (main) and DWELL=3 (sparse-mask case).
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, cont, ready;
    logic [3:0] mask, x;
    logic       s0, s1, f, valid, busy;
    logic [3:0] snap;

    logic       start3, ready3;
    logic [3:0] mask3;
    logic       s0b, s1b, fb, validb, busyb;
    logic [3:0] snapb;

`ifdef MUX_SCAN_DIFF_EN
    logic [3:0] chg, chgb;
`endif

    int tests = 0;
    int fails = 0;

    logic [1:0] seq2 [8];
    logic [1:0] seq3 [6];

    mux_4_to_1 u_mux (
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .S0(s0), .S1(s1), .F(f)
    );

    mux_scan_ctrl #(.DWELL(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .mask      (mask),
        .F         (f),
        .S0        (s0),
        .S1        (s1),
        .snap      (snap),
        .snap_valid(valid),
        .snap_ready(ready),
        .busy      (busy)
`ifdef MUX_SCAN_DIFF_EN
        ,
        .changed   (chg)
`endif
    );

    mux_4_to_1 u_mux3 (
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .S0(s0b), .S1(s1b), .F(fb)
    );

    mux_scan_ctrl #(.DWELL(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .cont      (1'b0),
        .mask      (mask3),
        .F         (fb),
        .S0        (s0b),
        .S1        (s1b),
        .snap      (snapb),
        .snap_valid(validb),
        .snap_ready(ready3),
        .busy      (busyb)
`ifdef MUX_SCAN_DIFF_EN
        ,
        .changed   (chgb)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        seq2 = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        seq3 = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};

        rst_n  = 1'b0;
        start  = 1'b0;
        cont   = 1'b0;
        ready  = 1'b0;
        mask   = 4'b0000;
        x      = 4'b0000;
        start3 = 1'b0;
        ready3 = 1'b0;
        mask3  = 4'b0000;
        #3;
        chk("rst_ctl", {4'b0, valid, busy, s0, s1}, 8'h00);
        chk("rst_snap", {4'b0, snap}, 8'h00);
        chk("rst_ctl3", {4'b0, validb, busyb, s0b, s1b}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Empty mask: straight to HOLD with snapshot 0000.
        mask  = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_hold", {4'b0, valid, busy, s0, s1}, 8'b0000_1100);
        chk("empty_snap", {4'b0, snap}, 8'h00);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("empty_idle", {6'b0, valid, busy}, 8'h00);

        // Single scan, x3..x0 = 1101, full mask; mask changes mid-scan.
        x     = 4'b1101;
        mask  = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask  = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("scan_sel%0d", k), {6'b0, s0, s1}, {6'b0, seq2[k]});
            chk($sformatf("scan_st%0d", k), {6'b0, busy, valid}, 8'b10);
            tick();
        end
        chk("scan_hold", {4'b0, valid, busy, s0, s1}, 8'b0000_1100);
        chk("scan_snap", {4'b0, snap}, 8'b0000_1101);
        tick();
        chk("scan_stable", {3'b0, valid, snap}, 8'b0001_1101);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("scan_idle", {6'b0, valid, busy}, 8'h00);

        // Sparse mask 0101, all inputs 1, DWELL=3 instance.
        x      = 4'b1111;
        mask3  = 4'b0101;
        ready3 = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("sparse_sel%0d", k), {6'b0, s0b, s1b},
                {6'b0, seq3[k]});
            chk($sformatf("sparse_st%0d", k), {6'b0, busyb, validb}, 8'b10);
            tick();
        end
        chk("sparse_hold", {4'b0, validb, busyb, s0b, s1b}, 8'b0000_1100);
        chk("sparse_snap", {4'b0, snapb}, 8'b0000_0101);
        chk("sparse_other_idle", {6'b0, busy, valid}, 8'h00);
        tick();
        ready3 = 1'b0;
        chk("sparse_idle", {6'b0, validb, busyb}, 8'h00);

        // Reset during the channel-2 dwell.
        x     = 4'b1101;
        mask  = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mid_sel", {6'b0, s0, s1}, 8'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {4'b0, valid, busy, s0, s1}, 8'h00);
        chk("mid_rst_snap", {4'b0, snap}, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_after", {4'b0, valid, busy, s0, s1}, 8'h00);

        // Continuous mode with backpressure, then a second snapshot.
        cont  = 1'b1;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cont_sel%0d", k), {6'b0, s0, s1}, {6'b0, seq2[k]});
            tick();
        end
        chk("cont_snap1", {3'b0, valid, snap}, 8'b0001_1101);
`ifdef MUX_SCAN_DIFF_EN
        chk("diff_first", {4'b0, chg}, 8'b0000_1101);
`endif
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), {1'b0, valid, s0, s1, snap},
                8'b0100_1101);
        end
        start = 1'b0;
        x     = 4'b1001;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("restart", {4'b0, valid, busy, s0, s1}, 8'b0000_0100);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("cont2_sel%0d", k), {6'b0, s0, s1}, {6'b0, seq2[k]});
        end
        tick();
        chk("cont_snap2", {3'b0, valid, snap}, 8'b0001_1001);
`ifdef MUX_SCAN_DIFF_EN
        chk("diff_second", {4'b0, chg}, 8'b0000_0100);
`endif
        cont  = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("cont_idle", {4'b0, valid, busy, s0, s1}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
